// File: rtl/pa_mem_model_if.sv
// Request/response channel between the backside translator and the
// physical-address memory model.
interface pa_mem_model_if #(
    parameter int IDX_W = 4,
    parameter int MCN_W = 58,
    parameter int PCN_W = 28
) ();
    logic             mem_req_i_ready;
    logic             mem_req_i_valid;
    logic [IDX_W-1:0] mem_req_i_bits_idx;
    logic             mem_req_i_bits_rnw;
    logic [MCN_W-1:0] mem_req_i_bits_mcn;
    logic [PCN_W-1:0] mem_req_i_bits_pcn;
    logic [511:0]     mem_req_i_bits_data;

    logic             mem_resp_o_ready;
    logic             mem_resp_o_valid;
    logic [IDX_W-1:0] mem_resp_o_bits_idx;
    logic             mem_resp_o_bits_err;
    logic             mem_resp_o_bits_rnw;
    logic [511:0]     mem_resp_o_bits_data;

    modport master (
        input  mem_req_i_ready,
        output mem_req_i_valid,
        output mem_req_i_bits_idx,
        output mem_req_i_bits_rnw,
        output mem_req_i_bits_mcn,
        output mem_req_i_bits_pcn,
        output mem_req_i_bits_data,
        output mem_resp_o_ready,
        input  mem_resp_o_valid,
        input  mem_resp_o_bits_idx,
        input  mem_resp_o_bits_err,
        input  mem_resp_o_bits_rnw,
        input  mem_resp_o_bits_data
    );

    modport slave (
        output mem_req_i_ready,
        input  mem_req_i_valid,
        input  mem_req_i_bits_idx,
        input  mem_req_i_bits_rnw,
        input  mem_req_i_bits_mcn,
        input  mem_req_i_bits_pcn,
        input  mem_req_i_bits_data,
        input  mem_resp_o_ready,
        output mem_resp_o_valid,
        output mem_resp_o_bits_idx,
        output mem_resp_o_bits_err,
        output mem_resp_o_bits_rnw,
        output mem_resp_o_bits_data
    );
endinterface

// File: rtl/pa_mem_model.sv
// Physical-address line memory: credit-admitted requests, fixed-latency
// pipeline, in-order response FIFO.
module pa_mem_model #(
    parameter int IDX_W   = 4,
    parameter int MCN_W   = 58,
    parameter int PCN_W   = 28,
    parameter int MEM_AW  = 10,
    parameter int RD_LAT  = 2,
    parameter int RSP_DEP = 4
) (
    input  logic          clock,
    input  logic          reset,
    pa_mem_model_if.slave bus
);
    localparam int CW = $clog2(RSP_DEP) + 1;
    localparam int PW = $clog2(RSP_DEP);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             err;
        logic             rnw;
        logic [511:0]     data;
    } rsp_t;

    logic [511:0]      mem_q [2**MEM_AW];
    rsp_t              pipe_q [RD_LAT];
    rsp_t              fifo_q [RSP_DEP];
    logic [CW-1:0]     credits_q, credits_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [RD_LAT-1:0] pv_q, pv_d;

    logic              accept;
    logic              push;
    logic              pop;
    logic              req_err;
    logic [MEM_AW-1:0] addr;
    rsp_t              stage_in;
    rsp_t              rsp_out;
    logic              unused_mcn;

    assign unused_mcn = ^bus.mem_req_i_bits_mcn;

    assign bus.mem_req_i_ready = (credits_q != '0) & ~reset;
    assign accept  = bus.mem_req_i_ready & bus.mem_req_i_valid;
    assign req_err = |bus.mem_req_i_bits_pcn[PCN_W-1:MEM_AW];
    assign addr    = bus.mem_req_i_bits_pcn[MEM_AW-1:0];

    assign push    = pv_q[RD_LAT-1];
    assign rsp_out = fifo_q[rd_ptr_q];
    assign bus.mem_resp_o_valid = (count_q != '0) & ~reset;
    assign pop     = bus.mem_resp_o_valid & bus.mem_resp_o_ready;

    assign bus.mem_resp_o_bits_idx  = rsp_out.idx;
    assign bus.mem_resp_o_bits_err  = rsp_out.err;
    assign bus.mem_resp_o_bits_rnw  = rsp_out.rnw;
    assign bus.mem_resp_o_bits_data = rsp_out.data;

    always_comb begin
        stage_in.idx  = bus.mem_req_i_bits_idx;
        stage_in.rnw  = bus.mem_req_i_bits_rnw;
        stage_in.err  = req_err;
        stage_in.data = '0;
        if (bus.mem_req_i_bits_rnw && !req_err) begin
            stage_in.data = mem_q[addr];
        end
    end

    always_comb begin
        credits_d = credits_q - CW'(accept) + CW'(pop);
        count_d   = count_q + CW'(push) - CW'(pop);
        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        pv_d      = '0;
        pv_d[0]   = accept;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
        end
        // In-flight requests vanish on reset; the array itself is kept.
        if (reset) begin
            credits_d = CW'(RSP_DEP);
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            pv_d      = '0;
        end
    end

    always_ff @(posedge clock) begin
        credits_q <= credits_d;
        count_q   <= count_d;
        wr_ptr_q  <= wr_ptr_d;
        rd_ptr_q  <= rd_ptr_d;
        pv_q      <= pv_d;
    end

    always_ff @(posedge clock) begin
        if (accept && !bus.mem_req_i_bits_rnw && !req_err) begin
            mem_q[addr] <= bus.mem_req_i_bits_data;
        end
        pipe_q[0] <= stage_in;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
        if (push) begin
            fifo_q[wr_ptr_q] <= pipe_q[RD_LAT-1];
        end
    end

    logic stall_q;
    rsp_t rsp_prev_q;

    always_ff @(posedge clock) begin
        stall_q    <= bus.mem_resp_o_valid & ~bus.mem_resp_o_ready;
        rsp_prev_q <= rsp_out;
        if (!reset) begin
            assert (credits_q <= CW'(RSP_DEP));
            assert (!(push && count_q == CW'(RSP_DEP)));
            assert (!stall_q || rsp_out == rsp_prev_q);
        end
    end
endmodule

// File: tb/tb_pa_mem_model.sv
// Scoreboard bench for pa_mem_model: reference line memory in an
// associative array, expectations queued at accept, popped at response.
module tb_pa_mem_model;
    localparam int IDX_W = 4;
    localparam int MCN_W = 58;
    localparam int PCN_W = 28;
    localparam int LAT   = 3;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic             rnw;
        logic             err;
        logic [511:0]     data;
        bit               chk_data;
        bit               chk_lat;
        int               cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   lat_mode = 1'b0;

    exp_t         q[$];
    logic [511:0] mdl[int];

    pa_mem_model_if #(.IDX_W(IDX_W), .MCN_W(MCN_W), .PCN_W(PCN_W)) bus ();

    pa_mem_model dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (bus.mem_resp_o_valid && bus.mem_resp_o_ready) begin
                if (q.size() == 0) begin
                    fail_now("resp_unexpected");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("resp_idx", 512'(bus.mem_resp_o_bits_idx), 512'(e.idx));
                    chk("resp_rnw", 512'(bus.mem_resp_o_bits_rnw), 512'(e.rnw));
                    chk("resp_err", 512'(bus.mem_resp_o_bits_err), 512'(e.err));
                    if (e.chk_data)
                        chk("resp_data", bus.mem_resp_o_bits_data, e.data);
                    if (e.chk_lat)
                        chk("resp_lat", 512'(cyc - e.cyc), 512'(LAT));
                end
            end
            if (bus.mem_req_i_ready && bus.mem_req_i_valid) begin
                exp_t e;
                int   a;
                a          = int'(bus.mem_req_i_bits_pcn);
                e.idx      = bus.mem_req_i_bits_idx;
                e.rnw      = bus.mem_req_i_bits_rnw;
                e.err      = (a >= 1024);
                e.data     = '0;
                e.chk_data = 1'b1;
                e.chk_lat  = lat_mode;
                e.cyc      = cyc;
                if (e.rnw && !e.err) begin
                    if (mdl.exists(a)) e.data = mdl[a];
                    else e.chk_data = 1'b0;
                end
                if (!e.rnw && !e.err) mdl[a] = bus.mem_req_i_bits_data;
                q.push_back(e);
            end
        end
    end

    function automatic logic [511:0] rnd512();
        logic [511:0] d;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit rnw, input logic [PCN_W-1:0] pcn,
                        input logic [IDX_W-1:0] idx, input logic [511:0] d,
                        output bit stalled);
        bus.mem_req_i_valid     = 1'b1;
        bus.mem_req_i_bits_rnw  = rnw;
        bus.mem_req_i_bits_pcn  = pcn;
        bus.mem_req_i_bits_idx  = idx;
        bus.mem_req_i_bits_data = d;
        bus.mem_req_i_bits_mcn  = {$urandom, $urandom};
        stalled = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.mem_req_i_ready) break;
            stalled = 1'b1;
            if (n == 199) fail_now("send_timeout");
        end
        @(posedge clk);
        #1;
        bus.mem_req_i_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || bus.mem_resp_o_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail_now("drain_timeout");
        idle(2);
    endtask

    task automatic reset_dut(input int n);
        rst = 1'b1;
        repeat (n) begin
            @(negedge clk);
            chk("rst_ready", 512'(bus.mem_req_i_ready), 512'(0));
            chk("rst_valid", 512'(bus.mem_resp_o_valid), 512'(0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 512'(bus.mem_req_i_ready), 512'(1));
        chk("post_rst_valid", 512'(bus.mem_resp_o_valid), 512'(0));
        idle(1);
    endtask

    task automatic backpressure(input logic [IDX_W-1:0] base);
        int acc;
        acc = 0;
        lat_mode = 1'b0;
        bus.mem_resp_o_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.mem_req_i_valid     = 1'b1;
            bus.mem_req_i_bits_rnw  = 1'b1;
            bus.mem_req_i_bits_pcn  = PCN_W'(i);
            bus.mem_req_i_bits_idx  = base + IDX_W'(i);
            bus.mem_req_i_bits_data = '0;
            @(negedge clk);
            if (bus.mem_req_i_ready) acc++;
            if (i >= 4) chk("bp_ready_low", 512'(bus.mem_req_i_ready), 512'(0));
            @(posedge clk);
            #1;
        end
        bus.mem_req_i_valid = 1'b0;
        chk("bp_accepts", 512'(acc), 512'(4));
        idle(3);
        bus.mem_resp_o_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid", 512'(bus.mem_resp_o_valid), 512'(1));
        chk("bp_ready_at_pop", 512'(bus.mem_req_i_ready), 512'(0));
        @(negedge clk);
        chk("bp_ready_after_pop", 512'(bus.mem_req_i_ready), 512'(1));
        drain();
        lat_mode = 1'b1;
    endtask

    initial begin
        bit           st;
        int           stalls;
        logic [511:0] pat;
        logic [511:0] d7;
        bus.mem_req_i_valid     = 1'b0;
        bus.mem_req_i_bits_idx  = '0;
        bus.mem_req_i_bits_rnw  = 1'b0;
        bus.mem_req_i_bits_mcn  = '0;
        bus.mem_req_i_bits_pcn  = '0;
        bus.mem_req_i_bits_data = '0;
        bus.mem_resp_o_ready    = 1'b1;

        reset_dut(2);
        lat_mode = 1'b1;

        for (int p = 0; p < 32; p++)
            send(1'b0, PCN_W'(p), IDX_W'(p), rnd512(), st);
        send(1'b0, 28'h3FF, 4'hF, rnd512(), st);
        drain();

        pat = {8{64'hA5A5_A5A5_A5A5_A5A5}};
        send(1'b0, 28'd5, 4'd3, pat, st);
        send(1'b1, 28'd5, 4'd4, '0, st);
        drain();

        send(1'b1, 28'h400, 4'd1, '0, st);
        send(1'b0, 28'h400, 4'd2, rnd512(), st);
        send(1'b1, 28'd0, 4'd3, '0, st);
        send(1'b1, 28'h3FF, 4'd5, '0, st);
        send(1'b1, 28'hFFF_FFFF, 4'd6, '0, st);
        drain();

        stalls = 0;
        for (int i = 0; i < 16; i++) begin
            send(1'b1, PCN_W'($urandom_range(0, 31)), IDX_W'($urandom), '0, st);
            stalls += int'(st);
        end
        chk("stream_no_stall", 512'(stalls), 512'(0));
        drain();

        backpressure(4'd8);

        d7 = rnd512();
        send(1'b0, 28'd7, 4'd0, d7, st);
        drain();
        send(1'b1, 28'd7, 4'd1, '0, st);
        send(1'b1, 28'd7, 4'd2, '0, st);
        send(1'b1, 28'd7, 4'd3, '0, st);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 512'(bus.mem_req_i_ready), 512'(0));
        chk("mid_rst_valid", 512'(bus.mem_resp_o_valid), 512'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("flushed_valid", 512'(bus.mem_resp_o_valid), 512'(0));
        end
        idle(1);
        backpressure(4'd0);
        send(1'b1, 28'd7, 4'd9, '0, st);
        drain();

        lat_mode = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.mem_req_i_valid     = ($urandom_range(0, 3) != 0);
            bus.mem_req_i_bits_rnw  = $urandom_range(0, 1) == 1;
            bus.mem_req_i_bits_idx  = IDX_W'($urandom);
            bus.mem_req_i_bits_data = rnd512();
            bus.mem_req_i_bits_mcn  = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0)
                bus.mem_req_i_bits_pcn = PCN_W'(32'h400 + $urandom_range(0, 5000));
            else
                bus.mem_req_i_bits_pcn = PCN_W'($urandom_range(0, 31));
            bus.mem_resp_o_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        bus.mem_req_i_valid  = 1'b0;
        bus.mem_resp_o_ready = 1'b1;
        drain();
        chk("final_queue_empty", 512'(q.size()), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
